// File: rtl/intt_pe_pipe.sv
// intt_pe_pipe
//   Three-stage Gentleman-Sande butterfly for the inverse NTT.
//   Each accepted operand set produces
//      x = (a + b) mod Q
//      y = ((a - b) * w) mod Q
//   When half=1, both results are also multiplied by 2^-1 mod Q.
//   This folds the per-stage 1/2 scaling of the INTT into the PE.
//
//   Ports
//      clk, rst_n        clock, asynchronous active-low reset
//      in_valid/ready    operand handshake (a, b, w, half, in_tag)
//      out_valid/ready   result handshake (x, y, out_tag)
//
//   Pipeline: S1 (mod add/sub) -> S2 (multiply) -> S3 (reduce, halve, output).
//   All stages advance together when the output register is empty or is
//   being drained. Bubbles are not collapsed, so a stall freezes the whole pipe.
module intt_pe_pipe #(
   parameter int unsigned Q     = 257,
   parameter int unsigned W     = 9,
   parameter int unsigned TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [W-1:0]     w,
   input  logic             half,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     x,
   output logic [W-1:0]     y,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [W:0]     QE = Q[W:0];
   localparam logic [2*W-1:0] QP = (2*W)'(Q);

   // v * 2^-1 mod Q: an odd v gets Q added first so that the shift is exact.
   function automatic logic [W-1:0] halve(input logic [W-1:0] v);
      logic [W:0] e;
      e = {1'b0, v} + (v[0] ? QE : '0);
      return W'(e >> 1);
   endfunction

   logic             adv;

   logic             v1, h1;
   logic [W-1:0]     x1, d1, w1;
   logic [TAG_W-1:0] t1;

   logic             v2, h2;
   logic [W-1:0]     x2;
   logic [2*W-1:0]   p2;
   logic [TAG_W-1:0] t2;

   logic [W:0]       s_sum, s_dif;
   logic [W-1:0]     x1_n, d1_n, r;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Adding Q before subtracting keeps the difference non-negative
   // within W+1 bits.
   assign s_sum = {1'b0, a} + {1'b0, b};
   assign s_dif = {1'b0, a} + QE - {1'b0, b};
   assign x1_n  = W'((s_sum >= QE) ? (s_sum - QE) : s_sum);
   assign d1_n  = W'((s_dif >= QE) ? (s_dif - QE) : s_dif);

   assign r = W'(p2 % QP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         h1        <= 1'b0;
         x1        <= '0;
         d1        <= '0;
         w1        <= '0;
         t1        <= '0;
         v2        <= 1'b0;
         h2        <= 1'b0;
         x2        <= '0;
         p2        <= '0;
         t2        <= '0;
         out_valid <= 1'b0;
         x         <= '0;
         y         <= '0;
         out_tag   <= '0;
      end else if (adv) begin
         v1        <= in_valid;
         h1        <= half;
         x1        <= x1_n;
         d1        <= d1_n;
         w1        <= w;
         t1        <= in_tag;

         v2        <= v1;
         h2        <= h1;
         x2        <= x1;
         p2        <= {{W{1'b0}}, d1} * {{W{1'b0}}, w1};
         t2        <= t1;

         out_valid <= v2;
         x         <= h2 ? halve(x2) : x2;
         y         <= h2 ? halve(r) : r;
         out_tag   <= t2;
      end
   end

endmodule

// File: tb/tb_intt_pe_pipe.sv
// Bench for intt_pe_pipe: two instances (Q=257/W=9 and Q=7681/W=13) share the
// handshake controls. Expected results come from plain modular arithmetic and
// are queued on acceptance; a negedge monitor pops and compares on each output
// transfer.
module tb_intt_pe_pipe;

   localparam int unsigned Q0 = 257;
   localparam int unsigned W0 = 9;
   localparam int unsigned Q1 = 7681;
   localparam int unsigned W1 = 13;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, out_ready, half;
   logic [7:0]    in_tag;
   logic [W0-1:0] a0, b0, w0, x0, y0;
   logic [W1-1:0] a1, b1, w1, x1, y1;
   logic          in_ready0, in_ready1, out_valid0, out_valid1;
   logic [7:0]    out_tag0, out_tag1;

   always #5 clk = ~clk;

   intt_pe_pipe #(.Q(Q0), .W(W0), .TAG_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a0), .b(b0), .w(w0), .half(half), .in_tag(in_tag),
      .out_valid(out_valid0), .out_ready(out_ready), .x(x0), .y(y0), .out_tag(out_tag0));

   intt_pe_pipe #(.Q(Q1), .W(W1), .TAG_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a1), .b(b1), .w(w1), .half(half), .in_tag(in_tag),
      .out_valid(out_valid1), .out_ready(out_ready), .x(x1), .y(y1), .out_tag(out_tag1));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: modular arithmetic on plain integers; halving is a multiply
   // by the modular inverse of 2, which is (q+1)/2 for odd q.
   function automatic void ref_op(input int unsigned a, b, w, input logic h,
                                  input int unsigned q,
                                  output int unsigned ex, output int unsigned ey);
      int unsigned inv2;
      inv2 = (q + 1) / 2;
      ex = (a + b) % q;
      ey = (((a + q - b) % q) * w) % q;
      if (h) begin
         ex = (ex * inv2) % q;
         ey = (ey * inv2) % q;
      end
   endfunction

   typedef struct {
      int unsigned x;
      int unsigned y;
      int unsigned tag;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   always @(negedge clk) begin : monitor
      exp_t        e;
      int unsigned ex, ey;
      if (!rst_n) begin
         sb0.delete();
         sb1.delete();
      end else begin
         if (out_valid0 && out_ready) begin
            if (sb0.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb0_extra got tag %0d expected no output", out_tag0);
            end else begin
               e = sb0.pop_front();
               check("sb0_x", x0, e.x);
               check("sb0_y", y0, e.y);
               check("sb0_tag", out_tag0, e.tag);
            end
         end
         if (out_valid1 && out_ready) begin
            if (sb1.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb1_extra got tag %0d expected no output", out_tag1);
            end else begin
               e = sb1.pop_front();
               check("sb1_x", x1, e.x);
               check("sb1_y", y1, e.y);
               check("sb1_tag", out_tag1, e.tag);
            end
         end
         if (in_valid && in_ready0) begin
            ref_op(a0, b0, w0, half, Q0, ex, ey);
            sb0.push_back('{ex, ey, in_tag});
         end
         if (in_valid && in_ready1) begin
            ref_op(a1, b1, w1, half, Q1, ex, ey);
            sb1.push_back('{ex, ey, in_tag});
         end
      end
   end

   // Presents one op and returns #1 after the edge that accepted it.
   task automatic send(input int unsigned av, bv, wv, input logic hv, input int unsigned tg);
      int n;
      a0 = W0'(av);
      b0 = W0'(bv);
      w0 = W0'(wv);
      a1 = W1'($urandom_range(0, Q1 - 1));
      b1 = W1'($urandom_range(0, Q1 - 1));
      w1 = W1'($urandom_range(0, Q1 - 1));
      half = hv;
      in_tag = 8'(tg);
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready0) break;
         n++;
         if (n > 300) begin
            check("send_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic directed(input string nm, input int unsigned av, bv, wv, input logic hv,
                           input int unsigned ex, ey);
      int lat;
      send(av, bv, wv, hv, 8'hA5);
      lat = 1;
      while (!out_valid0 && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({nm, "_lat"}, lat, 3);
      check({nm, "_x"}, x0, ex);
      check({nm, "_y"}, y0, ey);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((sb0.size() != 0 || sb1.size() != 0) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({nm, "_drain0"}, sb0.size(), 0);
      check({nm, "_drain1"}, sb1.size(), 0);
   endtask

   int unsigned sa[6], sbv[6], sw[6];
   logic        sh[6];
   bit          rnd_done;

   initial begin
      int unsigned ex, ey;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      half = 1'b0;
      in_tag = '0;
      a0 = '0; b0 = '0; w0 = '0;
      a1 = '0; b1 = '0; w1 = '0;
      #1;
      check("rst_valid", out_valid0, 0);
      check("rst_x", x0, 0);
      check("rst_y", y0, 0);
      check("rst_tag", out_tag0, 0);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready0, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      directed("t1", 10, 3, 2, 1'b0, 13, 14);
      directed("t2", 3, 10, 5, 1'b0, 13, 222);
      directed("t3a", 10, 3, 2, 1'b1, 135, 7);
      directed("t3b", 0, 1, 256, 1'b1, 129, 129);
      directed("t4", 256, 256, 256, 1'b0, 255, 0);
      drain("t4");

      // Stall with the pipe full.
      for (int i = 0; i < 6; i++) begin
         sa[i]  = $urandom_range(0, Q0 - 1);
         sbv[i] = $urandom_range(0, Q0 - 1);
         sw[i]  = $urandom_range(0, Q0 - 1);
         sh[i]  = 1'($urandom_range(0, 1));
      end
      ref_op(sa[0], sbv[0], sw[0], sh[0], Q0, ex, ey);
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(sa[i], sbv[i], sw[i], sh[i], i);
         end
         begin
            int n;
            n = 0;
            while (!out_valid0 && n < 20) begin
               @(negedge clk);
               n++;
            end
            check("t5_valid_seen", out_valid0, 1);
            repeat (5) begin
               @(negedge clk);
               check("t5_in_ready", in_ready0, 0);
               check("t5_hold_valid", out_valid0, 1);
               check("t5_hold_x", x0, ex);
               check("t5_hold_y", y0, ey);
               check("t5_hold_tag", out_tag0, 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain("t5");

      // Reset with three ops in flight.
      send(1, 2, 3, 1'b0, 10);
      send(4, 5, 6, 1'b1, 11);
      send(7, 8, 9, 1'b0, 12);
      rst_n = 1'b0;
      #1;
      check("t6_valid", out_valid0, 0);
      check("t6_x", x0, 0);
      check("t6_y", y0, 0);
      check("t6_tag", out_tag0, 0);
      check("t6_valid1", out_valid1, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check("t6_in_ready", in_ready0, 1);
      repeat (6) begin
         @(negedge clk);
         check("t6_no_stale", out_valid0, 0);
      end
      @(posedge clk);
      #1;
      directed("t6_new", 200, 100, 3, 1'b0, 43, 43);
      drain("t6");

      // Random traffic with random backpressure.
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               send($urandom_range(0, Q0 - 1), $urandom_range(0, Q0 - 1),
                    $urandom_range(0, Q0 - 1), 1'($urandom_range(0, 1)), i & 255);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain("rnd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
